// File: rtl/router_top.sv
// Ten independent dimension-ordered (XY) route computers for a 2-D mesh node.
// Latency: 1 cycle, dest_x/dest_y sampled on every rising edge into outport.
// Backpressure: none; the block accepts new coordinates every cycle.
module router_top #(
  parameter int CUR_X = 3,
  parameter int CUR_Y = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] dest_x,
  input  logic [29:0] dest_y,
  output logic [29:0] outport
);

  localparam logic [2:0] CX = 3'(CUR_X);
  localparam logic [2:0] CY = 3'(CUR_Y);

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_EAST  = 3'd1;
  localparam logic [2:0] P_WEST  = 3'd2;
  localparam logic [2:0] P_NORTH = 3'd3;
  localparam logic [2:0] P_SOUTH = 3'd4;

  logic [29:0] next_port;

  // Per-channel XY decision: X is resolved first, Y only matters once X matches.
  always_comb begin
    next_port = '0;
    for (int k = 0; k < 10; k++) begin
      if (dest_x[3*k +: 3] > CX) begin
        next_port[3*k +: 3] = P_EAST;
      end else if (dest_x[3*k +: 3] < CX) begin
        next_port[3*k +: 3] = P_WEST;
      end else if (dest_y[3*k +: 3] > CY) begin
        next_port[3*k +: 3] = P_NORTH;
      end else if (dest_y[3*k +: 3] < CY) begin
        next_port[3*k +: 3] = P_SOUTH;
      end else begin
        next_port[3*k +: 3] = P_LOCAL;
      end
    end
  end

  // Register all ten codes each edge; reset forces every channel to LOCAL at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outport <= '0;
    end else begin
      outport <= next_port;
    end
  end

endmodule

// File: tb/tb_router_top.sv
// Directed-vector bench for router_top at CUR_X=CUR_Y=3.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected port codes are hand-written constants.
module tb_router_top;

  logic        clk;
  logic        rst;
  logic [29:0] dest_x;
  logic [29:0] dest_y;
  logic [29:0] outport;

  int n_checks;
  int n_errors;

  logic [2:0] dxa [10];
  logic [2:0] dya [10];
  logic [2:0] expa [10];
  logic [29:0] exp_word;

  router_top #(.CUR_X(3), .CUR_Y(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .dest_x  (dest_x),
    .dest_y  (dest_y),
    .outport (outport)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [29:0] got, input logic [29:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Fill every channel with the same coordinate pair.
  task automatic fill(input logic [2:0] x, input logic [2:0] y);
    for (int k = 0; k < 10; k++) begin
      dxa[k] = x;
      dya[k] = y;
    end
  endtask

  // Drive the per-channel arrays onto the packed input buses.
  task automatic apply();
    for (int k = 0; k < 10; k++) begin
      dest_x[3*k +: 3] = dxa[k];
      dest_y[3*k +: 3] = dya[k];
    end
  endtask

  task automatic pack_exp();
    exp_word = '0;
    for (int k = 0; k < 10; k++) exp_word[3*k +: 3] = expa[k];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with arbitrary inputs and no clock edge yet.
    rst    = 1'b1;
    dest_x = 30'h2AAA_AAAA;
    dest_y = 30'h1555_5555;
    #1;
    check("reset_async", outport, 30'h0);

    // X dominance, channel 0 EAST.
    to_negedge();
    rst = 1'b0;
    fill(3'd3, 3'd3);
    dxa[0] = 3'd5; dya[0] = 3'd0;
    apply();
    tick();
    check("xdom_east_field", {27'h0, outport[2:0]}, 30'd1);
    check("xdom_east_word", outport, 30'h0000_0001);

    // Channel 0 WEST; output must hold until the next edge.
    to_negedge();
    dxa[0] = 3'd1; dya[0] = 3'd7;
    apply();
    #1;
    check("latency_hold", outport, 30'h0000_0001);
    tick();
    check("xdom_west_word", outport, 30'h0000_0002);

    // Y routing on channel 9.
    to_negedge();
    fill(3'd3, 3'd3);
    dxa[9] = 3'd3; dya[9] = 3'd6;
    apply();
    tick();
    check("y_north_field", {27'h0, outport[29:27]}, 30'd3);
    check("y_north_word", outport, 30'h1800_0000);

    to_negedge();
    dya[9] = 3'd0;
    apply();
    tick();
    check("y_south_word", outport, 30'h2000_0000);

    to_negedge();
    dya[9] = 3'd3;
    apply();
    tick();
    check("y_local_word", outport, 30'h0000_0000);

    // All channels at once.
    to_negedge();
    dest_x = 30'h3FFF_FFFF;
    dest_y = 30'h0;
    tick();
    check("all_east", outport, 30'h0924_9249);

    to_negedge();
    dest_x = 30'h0;
    dest_y = 30'h3FFF_FFFF;
    tick();
    check("all_west", outport, 30'h1249_2492);

    // Mid-cycle reset clears immediately and holds across an edge.
    #2;
    rst = 1'b1;
    #1;
    check("midcycle_reset", outport, 30'h0);
    to_negedge();
    dest_x = 30'h3FFF_FFFF;
    dest_y = 30'h0;
    tick();
    check("reset_hold_edge", outport, 30'h0);
    to_negedge();
    rst = 1'b0;
    #1;
    check("post_reset_pre_edge", outport, 30'h0);
    tick();
    check("post_reset_first_edge", outport, 30'h0924_9249);

    // Boundary mix: neighbours of CUR_X, extremes 0 and 7, plus Y cases.
    to_negedge();
    dxa[0] = 3'd4; dya[0] = 3'd0; expa[0] = 3'd1;
    dxa[1] = 3'd2; dya[1] = 3'd7; expa[1] = 3'd2;
    dxa[2] = 3'd0; dya[2] = 3'd3; expa[2] = 3'd2;
    dxa[3] = 3'd7; dya[3] = 3'd3; expa[3] = 3'd1;
    dxa[4] = 3'd3; dya[4] = 3'd4; expa[4] = 3'd3;
    dxa[5] = 3'd3; dya[5] = 3'd2; expa[5] = 3'd4;
    dxa[6] = 3'd4; dya[6] = 3'd0; expa[6] = 3'd1;
    dxa[7] = 3'd2; dya[7] = 3'd7; expa[7] = 3'd2;
    dxa[8] = 3'd3; dya[8] = 3'd3; expa[8] = 3'd0;
    dxa[9] = 3'd7; dya[9] = 3'd7; expa[9] = 3'd1;
    apply();
    tick();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("boundary_ch%0d", k), {27'h0, outport[3*k +: 3]}, {27'h0, expa[k]});
    end
    pack_exp();
    check("boundary_word", outport, exp_word);

    // Change only channel 4's Y; no other channel may move.
    to_negedge();
    dya[4] = 3'd2;
    expa[4] = 3'd4;
    apply();
    tick();
    pack_exp();
    check("isolation_ch4", outport, exp_word);

    // Change only channel 1's X across CUR_X; Y of others untouched.
    to_negedge();
    dxa[1] = 3'd7;
    expa[1] = 3'd1;
    apply();
    tick();
    pack_exp();
    check("isolation_ch1", outport, exp_word);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
